// File: rtl/prio_encoder_queue.sv
// prio_encoder_queue: sticky per-line event capture, presented one index at a
// time over valid/ready, in fixed-priority or round-robin order.

// Per-line pending flop: merges new events, drops the served bit and flags
// an event that lands on a bit that is already pending.
module pe_lane (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic req,
  input  logic served,
  output logic pend,
  output logic pnext,
  output logic hit
);

  // A same-cycle re-request of the served line re-arms it and is not a loss.
  assign pnext = (pend & ~served) | req;
  assign hit   = req & pend & ~served;

  // Pending bit; clear discards any req of the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) pend <= 1'b0;
    else              pend <= pnext;
  end

endmodule

module prio_encoder_queue #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             ready,
  input  logic             clear,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [IDX_W:0]   pend_cnt,
  output logic             lost
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  logic [N-1:0]     pending;
  logic [N-1:0]     pnext;
  logic [N-1:0]     hit;
  logic [N-1:0]     served;
  logic             acc;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] eff_last;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic [IDX_W:0]   cnt_next;

  assign acc = valid & ready;

  // One-hot of the index being accepted this cycle.
  always_comb begin
    served = '0;
    for (int i = 0; i < N; i++)
      served[i] = acc && (idx == IDX_W'(i));
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      pe_lane u_lane (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .req   (req[g]),
        .served(served[g]),
        .pend  (pending[g]),
        .pnext (pnext[g]),
        .hit   (hit[g])
      );
    end
  endgenerate

  // The pointer moves to idx on the accepting edge, so the load at that same
  // edge already scans from just past the index being served.
  assign eff_last = acc ? idx : last;
  assign start    = (eff_last == LAST_IDX) ? '0 : eff_last + 1'b1;

  // Selection over pending_next: highest index, or first set bit from start.
  always_comb begin
    int j;
    sel = '0;
    j   = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++)
        if (pnext[i]) sel = IDX_W'(i);
    end else begin
      // Scan downward in distance from start so the nearest hit wins.
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(start) + k;
        if (j >= N) j = j - N;
        if (pnext[j]) sel = IDX_W'(j);
      end
    end
  end

  // Popcount of pending_next.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N; i++)
      cnt_next = cnt_next + {{IDX_W{1'b0}}, pnext[i]};
  end

  // Output, status and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      idx      <= '0;
      pend_cnt <= '0;
      lost     <= 1'b0;
      last     <= LAST_IDX;
    end else if (clear) begin
      valid    <= 1'b0;
      idx      <= '0;
      pend_cnt <= '0;
      lost     <= 1'b0;
    end else begin
      pend_cnt <= cnt_next;
      lost     <= |hit;
      if (acc) last <= idx;
      // A presented but unaccepted index is held stable.
      if (!(valid && !ready)) begin
        valid <= |pnext;
        idx   <= sel;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Bench for prio_encoder_queue: directed steps plus random traffic, every
// cycle compared against an event-level reference model.
module tb_prio_encoder_queue;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic             mode = 1'b0;
  logic             ready = 1'b0;
  logic             clear = 1'b0;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [IDX_W:0]   pend_cnt;
  logic             lost;

  int errors = 0;
  int checks = 0;

  // Reference state
  bit [N-1:0] m_pend;
  bit         m_valid;
  bit         m_lost;
  int         m_idx;
  int         m_last;
  int         m_cnt;

  prio_encoder_queue #(.N(N), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mode    (mode),
    .ready   (ready),
    .clear   (clear),
    .idx     (idx),
    .valid   (valid),
    .pend_cnt(pend_cnt),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  function automatic int msel(bit [N-1:0] p, bit m, int lst);
    if (!m) begin
      for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (p[(lst + k) % N]) return (lst + k) % N;
    end
    return 0;
  endfunction

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    bit [N-1:0] srv;
    bit [N-1:0] pn;
    bit         a;
    if (rst) begin
      m_pend = '0; m_valid = 0; m_idx = 0; m_cnt = 0; m_lost = 0; m_last = N - 1;
    end else if (clear) begin
      m_pend = '0; m_valid = 0; m_idx = 0; m_cnt = 0; m_lost = 0;
    end else begin
      a   = m_valid && ready;
      srv = '0;
      if (a) srv[m_idx] = 1'b1;
      m_lost = |(req & m_pend & ~srv);
      pn     = (m_pend & ~srv) | req;
      m_pend = pn;
      m_cnt  = $countones(pn);
      if (a) m_last = m_idx;
      if (!(m_valid && !ready)) begin
        m_valid = |pn;
        m_idx   = msel(pn, mode, m_last);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: edge, model update, then compare registered outputs.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_valid", int'(valid), int'(m_valid));
    chk("m_idx", int'(idx), m_idx);
    chk("m_cnt", int'(pend_cnt), m_cnt);
    chk("m_lost", int'(lost), int'(m_lost));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clear = 1'b0; ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with requests asserted
    rst = 1'b1; req = 8'hFF;
    cyc(); cyc();
    chk("rst_valid", int'(valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_cnt", int'(pend_cnt), 0);
    chk("rst_lost", int'(lost), 0);
    rst = 1'b0; req = '0;
    cyc();
    chk("post_rst_valid", int'(valid), 0);

    // Fixed priority drain
    mode = 1'b0; ready = 1'b1; req = 8'b0100_1001;
    cyc(); req = '0;
    chk("fp_idx6", int'(idx), 6); chk("fp_cnt3", int'(pend_cnt), 3); chk("fp_v", int'(valid), 1);
    cyc();
    chk("fp_idx3", int'(idx), 3); chk("fp_cnt2", int'(pend_cnt), 2);
    cyc();
    chk("fp_idx0", int'(idx), 0); chk("fp_cnt1", int'(pend_cnt), 1);
    cyc();
    chk("fp_done_v", int'(valid), 0); chk("fp_done_cnt", int'(pend_cnt), 0);

    // Backpressure and loss
    ready = 1'b0; req = 8'hFF;
    cyc(); req = '0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_idx7", int'(idx), 7); chk("bp_cnt8", int'(pend_cnt), 8); chk("bp_v", int'(valid), 1);
      cyc();
    end
    req = 8'h80;
    cyc(); req = '0;
    chk("bp_lost1", int'(lost), 1); chk("bp_lost_cnt8", int'(pend_cnt), 8);
    cyc();
    chk("bp_lost0", int'(lost), 0);
    ready = 1'b1;
    for (int k = 6; k >= 0; k--) begin
      cyc();
      chk("bp_drain_idx", int'(idx), k);
    end
    cyc();
    chk("bp_drain_v", int'(valid), 0);

    // Round-robin order and wrap
    do_reset();
    mode = 1'b1; ready = 1'b1; req = 8'hFF;
    cyc(); req = '0;
    chk("rr_idx0", int'(idx), 0);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk("rr_idx", int'(idx), k);
    end
    cyc();
    chk("rr_empty", int'(valid), 0);
    req = 8'hFF;
    cyc(); req = '0;
    chk("rr2_idx0", int'(idx), 0);
    cyc(); chk("rr2_idx1", int'(idx), 1);
    cyc(); chk("rr2_idx2", int'(idx), 2);
    req = 8'h02;
    cyc(); req = '0;
    chk("rr2_idx3", int'(idx), 3);
    for (int k = 4; k < 8; k++) begin
      cyc();
      chk("rr2_idx", int'(idx), k);
    end
    cyc();
    chk("rr2_wrap_idx1", int'(idx), 1); chk("rr2_wrap_v", int'(valid), 1);

    // Serve and re-request in the same cycle
    do_reset();
    mode = 1'b0; ready = 1'b0; req = 8'h20;
    cyc();
    chk("sr_idx5", int'(idx), 5);
    ready = 1'b1;
    cyc(); req = '0;
    chk("sr_lost0", int'(lost), 0); chk("sr_v", int'(valid), 1);
    chk("sr_idx5b", int'(idx), 5); chk("sr_cnt1", int'(pend_cnt), 1);
    cyc();

    // Clear mid-operation
    do_reset();
    mode = 1'b0; ready = 1'b0; req = 8'h0F;
    cyc();
    chk("cl_cnt4", int'(pend_cnt), 4);
    clear = 1'b1; req = 8'h10;
    cyc(); clear = 1'b0; req = 8'h01;
    chk("cl_v0", int'(valid), 0); chk("cl_cnt0", int'(pend_cnt), 0); chk("cl_lost0", int'(lost), 0);
    cyc(); req = '0;
    chk("cl_idx0", int'(idx), 0); chk("cl_v1", int'(valid), 1);

    // Pointer survives clear in round-robin mode
    do_reset();
    mode = 1'b1; ready = 1'b1; req = 8'h02;
    cyc(); req = '0;
    chk("rp_idx1", int'(idx), 1);
    cyc();
    ready = 1'b0; req = 8'h0F;
    cyc();
    clear = 1'b1; req = '0;
    cyc(); clear = 1'b0; req = 8'h05;
    cyc(); req = '0;
    chk("rp_idx2", int'(idx), 2);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clear = ($urandom_range(0, 39) == 0);
      mode  = ($urandom_range(0, 15) == 0) ? ~mode : mode;
      ready = ($urandom_range(0, 2) != 0);
      req   = '0;
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
